// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package lsu_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // RV32I load width/sign codes.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store width codes.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Fault codes reported alongside the done pulse.
    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS   = 2'b10;

    // True when the width code exists for this direction and the offset suits the width.
    function automatic logic access_ok(input logic st, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (st) begin
            case (f3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = ~off[0];
                F3_SW:   ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = ~off[0];
                F3_LW:         ok = (off == 2'b00);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a read word and extends it to 32 bits.
module load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata[{byte_off, 3'b000} +: 8];
    assign sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

    // Extension by width code; anything else passes the word through.
    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  data = {24'h0, sel_byte};
            F3_LH:   data = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  data = {16'h0, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer between the core and an external data memory.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; request fields latched on acceptance
//   REQ     | mem_req held with stable address/strobes until mem_gnt
//   WAIT    | load granted, waiting for mem_rvalid
//   DONE    | one-cycle done pulse, fault valid
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Timeout fires on the last allowed cycle so the request lasts exactly TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             is_store_q, is_store_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [1:0]       fault_q, fault_d;
    logic [31:0]      load_data_q, load_data_d;
    logic [31:0]      aligned_data;
    logic             timed_out;

    load_align u_load_align (
        .funct3   (funct3_q),
        .byte_off (off_q),
        .rdata    (mem_rdata),
        .data     (aligned_data)
    );

    assign timed_out = (cnt_q == CNT_LAST);

    // Next-state, wait counter and latched request fields.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        fault_d     = fault_q;
        load_data_d = load_data_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    off_d       = addr[1:0];
                    funct3_d    = funct3;
                    is_store_d  = is_store;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_we_d    = is_store;
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = 32'h0;
                    if (is_store) begin
                        case (funct3)
                            F3_SB: begin
                                mem_wstrb_d = 4'b0001 << addr[1:0];
                                mem_wdata_d = {4{store_data[7:0]}};
                            end
                            F3_SH: begin
                                mem_wstrb_d = 4'b0011 << addr[1:0];
                                mem_wdata_d = {2{store_data[15:0]}};
                            end
                            F3_SW: begin
                                mem_wstrb_d = 4'b1111;
                                mem_wdata_d = store_data;
                            end
                            default: ;
                        endcase
                    end
                    if (access_ok(is_store, funct3, addr[1:0])) begin
                        state_d = ST_REQ;
                        fault_d = FAULT_NONE;
                    end else begin
                        state_d = ST_DONE;
                        fault_d = FAULT_ALIGN;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_gnt) begin
                    cnt_d = '0;
                    if (is_store_q) begin
                        state_d = ST_DONE;
                    end else if (mem_rvalid) begin
                        load_data_d = aligned_data;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (timed_out) begin
                    state_d = ST_DONE;
                    fault_d = FAULT_BUS;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    load_data_d = aligned_data;
                    state_d     = ST_DONE;
                end else if (timed_out) begin
                    state_d = ST_DONE;
                    fault_d = FAULT_BUS;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            is_store_q  <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
            fault_q     <= FAULT_NONE;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
        end
    end

    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign fault     = done ? fault_q : FAULT_NONE;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a short bus timeout.
module tb_load_store_unit;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  fault;
        logic [31:0] ld;
        int          done_cyc;
        int          req_cycles;
        logic [31:0] maddr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ld_model;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [1:0] off);
        int sz;
        sz = m_size(f3);
        if (sz == 0) return 0;
        if (st && f3[2]) return 0;
        if (!st && f3 == 3'b110) return 0;
        return (int'(off) % sz) == 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        int sz;
        sz = m_size(f3);
        for (int i = 0; i < 4; i++) s[i] = (i >= int'(off)) && (i < int'(off) + sz);
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = m_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_extract(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * int'(off));
        case (m_size(f3))
            1: return f3[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2: return f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    // One access: push expectation, drive bus responses, compare at done.
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd, input bit storm, input string name);
        exp_t e;
        bit   legal, fin, granted;
        int   cyc, gcyc, reqs;
        legal        = m_legal(st, f3, a[1:0]);
        e.maddr      = {a[31:2], 2'b00};
        e.we         = st;
        e.strb       = st ? m_strb(f3, a[1:0]) : 4'b0000;
        e.wdata      = m_wdata(f3, d);
        e.fault      = 2'b00;
        e.req_cycles = 0;
        if (!legal) begin
            e.fault    = 2'b01;
            e.done_cyc = 0;
        end else if (gnt_dly >= TMO) begin
            e.fault      = 2'b10;
            e.done_cyc   = TMO;
            e.req_cycles = TMO;
        end else begin
            e.req_cycles = gnt_dly + 1;
            if (st) begin
                e.done_cyc = gnt_dly + 1;
            end else if (rv_dly > TMO) begin
                e.fault    = 2'b10;
                e.done_cyc = gnt_dly + TMO + 1;
            end else begin
                e.done_cyc = gnt_dly + rv_dly + 1;
                ld_model   = m_extract(f3, a[1:0], rd);
            end
        end
        e.ld = ld_model;
        sb_q.push_back(e);

        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        @(posedge clk); #1;
        fin = 0; granted = 0; cyc = 0; gcyc = 0; reqs = 0;
        while (!fin && cyc < 40) begin
            start      = storm;
            is_store   = 1'($urandom);
            funct3     = 3'($urandom);
            addr       = $urandom;
            store_data = $urandom;
            if (done) begin
                fin = 1;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy cyc %0d got %b want 1", name, cyc, busy);
                end
                if (mem_req) begin
                    reqs++;
                    if (reqs == 1) begin
                        checks++;
                        if (mem_addr !== e.maddr || mem_we !== e.we || mem_wstrb !== e.strb ||
                            (st && mem_wdata !== e.wdata)) begin
                            errors++;
                            $display("FAIL %s bus got addr=%h we=%b strb=%b wdata=%h want addr=%h we=%b strb=%b wdata=%h",
                                     name, mem_addr, mem_we, mem_wstrb, mem_wdata,
                                     e.maddr, e.we, e.strb, e.wdata);
                        end
                    end
                end
                mem_gnt = mem_req && (cyc >= gnt_dly);
                if (st) mem_rvalid = 1'b0;
                else if (granted) mem_rvalid = (cyc >= gcyc + rv_dly);
                else mem_rvalid = mem_gnt && (rv_dly == 0);
                mem_rdata = mem_rvalid ? rd : $urandom;
                if (mem_gnt) gcyc = cyc;
                @(posedge clk); #1;
                if (mem_gnt) granted = 1;
                cyc++;
            end
        end
        start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s done never seen within %0d cycles", name, cyc);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s done with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            if (cyc !== e.done_cyc || fault !== e.fault || load_data !== e.ld ||
                reqs !== e.req_cycles) begin
                errors++;
                $display("FAIL %s result got cyc=%0d fault=%b ld=%h reqs=%0d want cyc=%0d fault=%b ld=%h reqs=%0d",
                         name, cyc, fault, load_data, reqs, e.done_cyc, e.fault, e.ld, e.req_cycles);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fault !== 2'b00 || load_data !== ld_model) begin
            errors++;
            $display("FAIL %s idle got busy=%b done=%b fault=%b ld=%h want 0 0 00 %h",
                     name, busy, done, fault, load_data, ld_model);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0 ||
            mem_wdata !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || fault !== 2'b00 ||
            load_data !== 32'h0) begin
            errors++;
            $display("FAIL %s got req=%b we=%b addr=%h strb=%b wdata=%h done=%b busy=%b fault=%b ld=%h want all zero",
                     name, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, done, busy, fault, load_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0;
        store_data = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        ld_model = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        run_op(1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, "sw_0x100");
        run_op(1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0, 0, "sb_0x103");
        run_op(1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 2, 0, 32'h0, 0, "sh_0x102");
        run_op(1, 3'b000, 32'h0000_0401, 32'h0000_0077, 1, 0, 32'h0, 0, "sb_0x401");
    endtask

    task automatic test_load();
        run_op(0, 3'b000, 32'h0000_0202, 32'h0, 0, 3, 32'h0080_0000, 0, "lb_0x202");
        run_op(0, 3'b100, 32'h0000_0202, 32'h0, 0, 3, 32'h0080_0000, 0, "lbu_0x202");
        run_op(0, 3'b001, 32'h0000_0206, 32'h0, 1, 0, 32'h8001_1234, 0, "lh_0x206");
        run_op(0, 3'b101, 32'h0000_0204, 32'h0, 0, 0, 32'h8001_9234, 0, "lhu_0x204");
        run_op(0, 3'b010, 32'h0000_0300, 32'h0, 2, 1, 32'hCAFE_F00D, 0, "lw_0x300");
    endtask

    task automatic test_illegal();
        run_op(0, 3'b010, 32'h0000_0102, 32'h0, 0, 0, 32'h1111_1111, 0, "lw_misaligned");
        run_op(0, 3'b011, 32'h0000_0200, 32'h0, 0, 0, 32'h2222_2222, 0, "load_f3_011");
        run_op(0, 3'b110, 32'h0000_0200, 32'h0, 0, 0, 32'h2222_2222, 0, "load_f3_110");
        run_op(1, 3'b100, 32'h0000_0200, 32'h5, 0, 0, 32'h0, 0, "store_f3_100");
        run_op(0, 3'b001, 32'h0000_0101, 32'h0, 0, 0, 32'h3333_3333, 0, "lh_odd");
        run_op(1, 3'b010, 32'h0000_0102, 32'h5, 0, 0, 32'h0, 0, "sw_misaligned");
    endtask

    task automatic test_timeout();
        run_op(0, 3'b010, 32'h0000_0500, 32'h0, 99, 0, 32'h0, 0, "no_gnt_timeout");
        run_op(0, 3'b000, 32'h0000_0501, 32'h0, 0, 20, 32'h4444_4444, 0, "no_rvalid_timeout");
        run_op(1, 3'b010, 32'h0000_0504, 32'h9, TMO - 1, 0, 32'h0, 0, "gnt_last_cycle");
    endtask

    task automatic test_back_to_back();
        run_op(1, 3'b010, 32'h0000_0600, 32'h0BAD_F00D, 3, 0, 32'h0, 1, "store_start_storm");
        run_op(0, 3'b000, 32'h0000_0603, 32'h0, 1, 2, 32'h7F00_0000, 1, "load_start_storm");
    endtask

    task automatic test_reset_mid();
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0700;
        @(posedge clk); #1;
        start = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait_state got busy=%b req=%b want 1 0", busy, mem_req);
        end
        rst_n = 1'b0;
        #1;
        ld_model = 32'h0;
        check_reset_outputs("reset_mid_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFEED_FACE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_reset_outputs("reset_mid_late_resp");
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        run_op(0, 3'b010, 32'h0000_0704, 32'h0, 0, 0, 32'h0123_4567, 0, "after_reset_lw");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_op(1'($urandom), 3'($urandom), $urandom, $urandom,
                   ($urandom_range(0, 9) == 9) ? 12 : int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), $urandom, 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
